cnt32_checker: RTL and testbench
================================

CNT32_CHECKER -- requirements
Module: cnt32_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive +1 steps required before lock; legal range 1..255.
REQ-002 Parameter STOP_ON_ERR, default 1: 1 = halt on a mismatch while locked; 0 = re-acquire on a mismatch while locked.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cnt_in  input  32  sample of the upstream free-running 32-bit counter, one value per clk.
REQ-006 enable  input  1  checker active when high.
REQ-007 clear_err  input  1  one-cycle request to clear the error record and leave HALT.
REQ-008 locked  output  1  high while state = LOCKED.
REQ-009 err_pulse  output  1  one-cycle strobe per detected mismatch while locked.
REQ-010 err_sticky  output  1  set by any err_pulse; held until clear_err or reset.
REQ-011 err_cnt  output  16  saturating count of mismatches detected while locked.
REQ-012 last_bad  output  32  cnt_in value that caused the most recent mismatch.
REQ-013 state  output  2  IDLE=0, ACQUIRE=1, LOCKED=2, HALT=3.

Function
REQ-014 All outputs shall be registered; none shall depend combinationally on inputs.
REQ-015 A match in cycle N shall mean cnt_in == prev + 1 modulo 2^32, where prev is the cnt_in sampled in cycle N-1.
REQ-016 The step 0xFFFFFFFF -> 0x00000000 shall be a match.
REQ-017 prev shall load cnt_in on every cycle in which enable is high.
REQ-018 IDLE: with enable high, the block shall capture prev, clear run_cnt, and enter ACQUIRE next cycle.
REQ-019 ACQUIRE on a match: run_cnt increments; when run_cnt reaches LOCK_CNT, state shall become LOCKED, and locked shall rise in the cycle after the LOCK_CNT-th consecutive match.
REQ-020 ACQUIRE on a mismatch: run_cnt shall clear to 0; state stays ACQUIRE; err_pulse, err_cnt and last_bad are unchanged.
REQ-021 LOCKED on a match: no change.
REQ-022 LOCKED on a mismatch in cycle N, in cycle N+1: err_pulse=1 for exactly one cycle, err_sticky=1, err_cnt+1, last_bad=cnt_in(N).
REQ-023 Same mismatch, next state: HALT if STOP_ON_ERR=1, else ACQUIRE with run_cnt=0.
REQ-024 HALT: state shall be held with no further comparisons.
REQ-025 HALT with clear_err high: next state ACQUIRE with run_cnt=0 and prev<=cnt_in.
REQ-026 err_cnt shall saturate at 0xFFFF; at saturation, further mismatches still pulse err_pulse.
REQ-027 clear_err in any state shall zero err_cnt and err_sticky next cycle; last_bad shall be retained.
REQ-028 clear_err coincident with a LOCKED mismatch: error wins -> err_cnt=1, err_sticky=1, err_pulse=1; STOP_ON_ERR=1 enters HALT.
REQ-029 enable low in any state: IDLE next cycle, locked=0, run_cnt=0; err_cnt, err_sticky and last_bad shall be retained.
REQ-030 enable low shall take priority over clear_err for the state transition, but clear_err shall still clear the error record.
REQ-031 run_cnt shall be 8 bits wide and shall not increment past LOCK_CNT.

Reset
REQ-032 reset high at a clk edge shall, next cycle, set state=IDLE and zero locked, err_pulse, err_sticky, err_cnt, last_bad, run_cnt and prev.
REQ-033 reset shall take priority over enable, clear_err and any comparison result.
REQ-034 reset asserted mid-operation, including in LOCKED or HALT, shall behave identically to reset at power-up.

Verification
REQ-035 Lock: reset, enable=1, cnt_in=100,101,102,... -> locked=1 in the cycle after cnt_in=104 is sampled; state=2; err_cnt=0.
REQ-036 Wrap: locked, cnt_in=0xFFFFFFFE,0xFFFFFFFF,0x00000000,0x00000001 -> no err_pulse; locked stays 1.
REQ-037 Halt: STOP_ON_ERR=1, locked at 500, cnt_in jumps 500->510 -> next cycle err_pulse=1, err_cnt=1, last_bad=510, state=3; pulse lasts one cycle; clear_err -> state=1, err_cnt=0, err_sticky=0, last_bad=510.
REQ-038 Re-acquire: STOP_ON_ERR=0, three isolated jumps each after relock -> err_cnt=3, err_sticky=1, three single-cycle err_pulses, relock each time after 4 good steps.
REQ-039 Simultaneous: clear_err coincident with a LOCKED mismatch when err_cnt=7 -> err_cnt=1, err_sticky=1, err_pulse=1.
REQ-040 Disruption: enable dropped while locked -> state=0, locked=0, err_cnt retained; reset while in HALT -> all outputs 0, state=0.

Source files
------------

// File: rtl/cnt32_checker.sv
// cnt32_checker: watches a free-running 32-bit counter sample stream,
// locks after a run of +1 steps and records any step errors seen while locked.
module cnt32_checker #(
  parameter int unsigned LOCK_CNT    = 4,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cnt_in,
  input  logic        enable,
  input  logic        clear_err,
  output logic        locked,
  output logic        err_pulse,
  output logic        err_sticky,
  output logic [15:0] err_cnt,
  output logic [31:0] last_bad,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HALT    = 2'd3
  } state_e;

  localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);

  state_e      state_q, state_d;
  logic [31:0] prev_q, prev_d;
  logic [7:0]  run_q, run_d;
  logic        locked_q, locked_d;
  logic        pulse_q, pulse_d;
  logic        sticky_q, sticky_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic [31:0] bad_q, bad_d;
  logic        match;

  // +1 step, naturally wrapping 0xFFFFFFFF -> 0
  assign match = (cnt_in == prev_q + 32'd1);

  // Next-state: error record first, then enable gate, then per-state rules
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    run_d    = run_q;
    pulse_d  = 1'b0;
    sticky_d = sticky_q;
    ecnt_d   = ecnt_q;
    bad_d    = bad_q;
    if (clear_err) begin
      ecnt_d   = 16'd0;
      sticky_d = 1'b0;
    end
    if (!enable) begin
      state_d = IDLE;
      run_d   = 8'd0;
    end else begin
      prev_d = cnt_in;
      unique case (state_q)
        IDLE: begin
          run_d   = 8'd0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (!match) begin
            run_d = 8'd0;
          end else if (run_q >= LOCK_N - 8'd1) begin
            run_d   = LOCK_N;
            state_d = LOCKED;
          end else begin
            run_d = run_q + 8'd1;
          end
        end
        LOCKED: begin
          if (!match) begin
            pulse_d  = 1'b1;
            sticky_d = 1'b1;
            bad_d    = cnt_in;
            if (ecnt_d != 16'hFFFF)
              ecnt_d = ecnt_d + 16'd1;
            run_d   = 8'd0;
            state_d = STOP_ON_ERR ? HALT : ACQUIRE;
          end
        end
        HALT: begin
          if (clear_err) begin
            run_d   = 8'd0;
            state_d = ACQUIRE;
          end
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prev_q   <= 32'd0;
      run_q    <= 8'd0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      ecnt_q   <= 16'd0;
      bad_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      ecnt_q   <= ecnt_d;
      bad_q    <= bad_d;
    end
  end

  assign state      = state_q;
  assign locked     = locked_q;
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = ecnt_q;
  assign last_bad   = bad_q;

endmodule

// File: tb/tb_cnt32_checker.sv
// tb_cnt32_checker: directed scenarios plus random stream on two checkers
// (halting and re-acquiring) against a spec-level reference model.
module tb_cnt32_checker;

  localparam int LOCK = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cnt_in = 32'd0;
  logic        enable = 1'b0;
  logic        clear_err = 1'b0;

  logic        lk_o [2];
  logic        pl_o [2];
  logic        sk_o [2];
  logic [15:0] ec_o [2];
  logic [31:0] lb_o [2];
  logic [1:0]  st_o [2];

  int n_chk = 0;
  int n_fail = 0;
  int pcnt0 = 0;

  // reference model state, index 1 halts on error, index 0 re-acquires
  int          ms [2];
  int          mrun [2];
  logic [31:0] mprev [2];
  logic [31:0] mbad [2];
  int          mcnt [2];
  bit          mst [2];
  bit          mpl [2];

  always #5 clk = ~clk;

  cnt32_checker #(.LOCK_CNT(LOCK), .STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .enable(enable),
    .clear_err(clear_err), .locked(lk_o[1]), .err_pulse(pl_o[1]),
    .err_sticky(sk_o[1]), .err_cnt(ec_o[1]), .last_bad(lb_o[1]),
    .state(st_o[1])
  );

  cnt32_checker #(.LOCK_CNT(LOCK), .STOP_ON_ERR(1'b0)) u0 (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .enable(enable),
    .clear_err(clear_err), .locked(lk_o[0]), .err_pulse(pl_o[0]),
    .err_sticky(sk_o[0]), .err_cnt(ec_o[0]), .last_bad(lb_o[0]),
    .state(st_o[0])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit clr,
                            input logic [31:0] c);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] want;
      mpl[k] = 1'b0;
      if (rst) begin
        ms[k] = 0; mrun[k] = 0; mprev[k] = 0;
        mbad[k] = 0; mcnt[k] = 0; mst[k] = 0;
        continue;
      end
      if (clr) begin
        mcnt[k] = 0;
        mst[k] = 0;
      end
      if (!en) begin
        ms[k] = 0;
        mrun[k] = 0;
        continue;
      end
      want = mprev[k] + 32'd1;
      if (ms[k] == 0) begin
        mrun[k] = 0;
        ms[k] = 1;
      end else if (ms[k] == 1) begin
        if (c == want) begin
          mrun[k] = mrun[k] + 1;
          if (mrun[k] >= LOCK) begin
            mrun[k] = LOCK;
            ms[k] = 2;
          end
        end else begin
          mrun[k] = 0;
        end
      end else if (ms[k] == 2) begin
        if (c != want) begin
          mpl[k] = 1'b1;
          mst[k] = 1'b1;
          mcnt[k] = (mcnt[k] >= 65535) ? 65535 : mcnt[k] + 1;
          mbad[k] = c;
          mrun[k] = 0;
          ms[k] = (k == 1) ? 3 : 1;
        end
      end else if (clr) begin
        mrun[k] = 0;
        ms[k] = 1;
      end
      mprev[k] = c;
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input bit clr,
                     input logic [31:0] c);
    reset = rst;
    enable = en;
    clear_err = clr;
    cnt_in = c;
    @(posedge clk);
    model_step(rst, en, clr, c);
    #1;
    if (pl_o[0] === 1'b1) pcnt0++;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d_state", k), 32'(st_o[k]), 32'(ms[k]));
      chk($sformatf("m%0d_locked", k), 32'(lk_o[k]), 32'(ms[k] == 2));
      chk($sformatf("m%0d_pulse", k), 32'(pl_o[k]), 32'(mpl[k]));
      chk($sformatf("m%0d_sticky", k), 32'(sk_o[k]), 32'(mst[k]));
      chk($sformatf("m%0d_errcnt", k), 32'(ec_o[k]), 32'(mcnt[k]));
      chk($sformatf("m%0d_lastbad", k), lb_o[k], mbad[k]);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] cur;
    bit rr, re, rc;

    // reset state
    cyc(1, 0, 0, 32'd0);
    cyc(1, 1, 1, 32'd7);
    chk("rst_state", 32'(st_o[1]), 32'd0);
    chk("rst_errcnt", 32'(ec_o[1]), 32'd0);
    chk("rst_lastbad", lb_o[1], 32'd0);

    // lock on 100,101,...
    for (int i = 0; i <= 4; i++) begin
      cyc(0, 1, 0, 32'd100 + 32'(i));
      if (i == 3) chk("lock_early", 32'(lk_o[1]), 32'd0);
    end
    chk("lock_locked", 32'(lk_o[1]), 32'd1);
    chk("lock_state", 32'(st_o[1]), 32'd2);
    chk("lock_errcnt", 32'(ec_o[1]), 32'd0);

    // wrap through 0xFFFFFFFF -> 0
    cyc(1, 0, 0, 32'd0);
    v = 32'hFFFF_FFFA;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, v);
      if (i >= 4) begin
        chk("wrap_pulse", 32'(pl_o[1]), 32'd0);
        chk("wrap_locked", 32'(lk_o[1]), 32'd1);
      end
      v = v + 32'd1;
    end

    // halt on a 500 -> 510 jump, then clear
    cyc(1, 0, 0, 32'd0);
    for (int i = 496; i <= 500; i++) cyc(0, 1, 0, 32'(i));
    cyc(0, 1, 0, 32'd510);
    chk("halt_pulse", 32'(pl_o[1]), 32'd1);
    chk("halt_errcnt", 32'(ec_o[1]), 32'd1);
    chk("halt_lastbad", lb_o[1], 32'd510);
    chk("halt_state", 32'(st_o[1]), 32'd3);
    cyc(0, 1, 0, 32'd511);
    chk("halt_pulse_end", 32'(pl_o[1]), 32'd0);
    chk("halt_held", 32'(st_o[1]), 32'd3);
    cyc(0, 1, 1, 32'd512);
    chk("clr_state", 32'(st_o[1]), 32'd1);
    chk("clr_errcnt", 32'(ec_o[1]), 32'd0);
    chk("clr_sticky", 32'(sk_o[1]), 32'd0);
    chk("clr_lastbad", lb_o[1], 32'd510);

    // re-acquire after isolated jumps, building err_cnt to 7
    cyc(1, 0, 0, 32'd0);
    pcnt0 = 0;
    v = 32'd2000;
    cyc(0, 1, 0, v);
    for (int j = 0; j < 7; j++) begin
      for (int s = 0; s < 4; s++) begin
        v = v + 32'd1;
        cyc(0, 1, 0, v);
        if (s == 0) chk("reacq_pulse_end", 32'(pl_o[0]), 32'd0);
      end
      chk("reacq_relock", 32'(lk_o[0]), 32'd1);
      v = v + 32'd50;
      cyc(0, 1, 0, v);
      chk("reacq_pulse", 32'(pl_o[0]), 32'd1);
      chk("reacq_state", 32'(st_o[0]), 32'd1);
      if (j == 2) begin
        chk("reacq_errcnt3", 32'(ec_o[0]), 32'd3);
        chk("reacq_sticky", 32'(sk_o[0]), 32'd1);
        chk("reacq_npulse", 32'(pcnt0), 32'd3);
      end
    end

    // clear_err coincident with a locked mismatch
    for (int s = 0; s < 4; s++) begin
      v = v + 32'd1;
      cyc(0, 1, 0, v);
    end
    chk("simul_pre", 32'(ec_o[0]), 32'd7);
    v = v + 32'd50;
    cyc(0, 1, 1, v);
    chk("simul_errcnt", 32'(ec_o[0]), 32'd1);
    chk("simul_sticky", 32'(sk_o[0]), 32'd1);
    chk("simul_pulse", 32'(pl_o[0]), 32'd1);

    // enable dropped while locked
    for (int s = 0; s < 4; s++) begin
      v = v + 32'd1;
      cyc(0, 1, 0, v);
    end
    cyc(0, 0, 0, v + 32'd1);
    chk("dis_state", 32'(st_o[0]), 32'd0);
    chk("dis_locked", 32'(lk_o[0]), 32'd0);
    chk("dis_errcnt", 32'(ec_o[0]), 32'd1);

    // reset while in HALT
    v = 32'd9000;
    cyc(0, 1, 0, v);
    for (int s = 0; s < 4; s++) begin
      v = v + 32'd1;
      cyc(0, 1, 0, v);
    end
    cyc(0, 1, 0, v + 32'd3);
    chk("pre_rst_halt", 32'(st_o[1]), 32'd3);
    cyc(1, 1, 0, v + 32'd4);
    chk("rsth_state", 32'(st_o[1]), 32'd0);
    chk("rsth_errcnt", 32'(ec_o[1]), 32'd0);
    chk("rsth_sticky", 32'(sk_o[1]), 32'd0);
    chk("rsth_lastbad", lb_o[1], 32'd0);

    // random stream against the model
    cur = $urandom;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      re = ($urandom_range(0, 19) != 0);
      rc = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 39))
        0, 1, 2: cur = $urandom;
        3: cur = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        4: cur = cur + 32'd2;
        default: cur = cur + 32'd1;
      endcase
      cyc(rr, re, rc, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
